// File: rtl/pkt_ser_pkg.sv
// pkt_ser_pkg: FSM states and default parameters shared by the pkt_serializer slice
package pkt_ser_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_BEATS_MAX    = 128;
  localparam int DEF_PRIORITY_BIT = 3;
  localparam int DEF_ADDR_BIT     = 16;
  localparam int DEF_RD_LEN       = 4;
endpackage

// File: rtl/pkt_ser_beat_sel.sv
// pkt_ser_beat_sel: picks beat idx from a pack whose beat 0 sits in the MSBs
module pkt_ser_beat_sel #(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS_MAX  = 128,
  localparam int PACK_BIT  = DATA_WIDTH * BEATS_MAX,
  localparam int LEN_BIT   = $clog2(BEATS_MAX + 1)
) (
  input  logic [PACK_BIT-1:0]   pack,
  input  logic [LEN_BIT-1:0]    idx,
  output logic [DATA_WIDTH-1:0] data
);
  assign data = pack[PACK_BIT - 1 - int'(idx) * DATA_WIDTH -: DATA_WIDTH];
endmodule

// File: rtl/pkt_serializer.sv
// pkt_serializer: pack-to-beat serializer with sop/eop, rd/wr command pulses, optional stats under PKT_SER_STATS_EN
module pkt_serializer
  import pkt_ser_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BEATS_MAX    = DEF_BEATS_MAX,
  parameter int PRIORITY_BIT = DEF_PRIORITY_BIT,
  parameter int ADDR_BIT     = DEF_ADDR_BIT,
  parameter int RD_LEN       = DEF_RD_LEN,
  localparam int PACK_BIT    = DATA_WIDTH * BEATS_MAX,
  localparam int LEN_BIT     = $clog2(BEATS_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PACK_BIT-1:0]     in_pack,
  input  logic [LEN_BIT-1:0]      in_len,
  input  logic [PRIORITY_BIT-1:0] in_prior,
  input  logic [ADDR_BIT-1:0]     in_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [PRIORITY_BIT-1:0] out_prior,
  output logic [ADDR_BIT-1:0]     out_addr,
  output logic                    wr_ena,
  output logic                    rd_ena,
  output logic                    err_len
`ifdef PKT_SER_STATS_EN
  ,
  output logic [31:0]             stat_pkts,
  output logic [15:0]             stat_drops
`endif
);
  state_t state, state_nx;
  logic [PACK_BIT-1:0] pack_q;
  logic [LEN_BIT-1:0] len_q, k;
  logic [DATA_WIDTH-1:0] beat;
  logic acc, len_ok, last, fire;
  assign acc       = in_valid & in_ready;
  assign len_ok    = (in_len != '0) && (in_len <= LEN_BIT'(BEATS_MAX));
  assign last      = (k == len_q - 1'b1);
  assign out_valid = (state == SEND);
  assign fire      = out_valid & out_ready;
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_sop   = out_valid & (k == '0);
  assign out_eop   = out_valid & last;
  assign out_data  = out_valid ? beat : '0;
  pkt_ser_beat_sel #(.DATA_WIDTH(DATA_WIDTH), .BEATS_MAX(BEATS_MAX)) u_sel (
    .pack(pack_q),
    .idx (k),
    .data(beat)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? ((acc && len_ok) ? SEND : IDLE) : ((fire && last) ? IDLE : SEND);
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q    <= '0;
      len_q     <= '0;
      k         <= '0;
      out_prior <= '0;
      out_addr  <= '0;
      wr_ena    <= 1'b0;
      rd_ena    <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      wr_ena  <= fire && last && (len_q != LEN_BIT'(RD_LEN));
      rd_ena  <= fire && last && (len_q == LEN_BIT'(RD_LEN));
      err_len <= acc && !len_ok;
      if (acc && len_ok) begin
        pack_q    <= in_pack;
        len_q     <= in_len;
        k         <= '0;
        out_prior <= in_prior;
        out_addr  <= in_addr;
      end else if (fire) begin
        k <= k + 1'b1;
      end
    end
  end
`ifdef PKT_SER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts  <= '0;
      stat_drops <= '0;
    end else begin
      if (fire && last) stat_pkts <= stat_pkts + 32'd1;
      if (acc && !len_ok && !(&stat_drops)) stat_drops <= stat_drops + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pkt_serializer.sv
// tb_pkt_serializer: directed and random packets checked against a byte-list reference model
module tb_pkt_serializer;
  localparam int DW  = 8;
  localparam int BM  = 128;
  localparam int PB  = DW * BM;
  localparam int LB  = $clog2(BM + 1);
  localparam int PW  = 3;
  localparam int AW  = 16;
  localparam int RDL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [PB-1:0] in_pack = '0;
  logic [LB-1:0] in_len = '0;
  logic [PW-1:0] in_prior = '0;
  logic [AW-1:0] in_addr = '0;
  logic out_valid, out_sop, out_eop, wr_ena, rd_ena, err_len;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_prior;
  logic [AW-1:0] out_addr;
`ifdef PKT_SER_STATS_EN
  logic [31:0] stat_pkts;
  logic [15:0] stat_drops;
`endif
  int tests = 0;
  int fails = 0;
  int pkts_done = 0;
  always #5 clk = ~clk;
  pkt_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pack(in_pack),
    .in_len(in_len), .in_prior(in_prior), .in_addr(in_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_prior(out_prior), .out_addr(out_addr), .wr_ena(wr_ena), .rd_ena(rd_ena), .err_len(err_len)
`ifdef PKT_SER_STATS_EN
    , .stat_pkts(stat_pkts), .stat_drops(stat_drops)
`endif
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // mode 0: always ready, 1: random ready, 2: stall two cycles at beat 1, 3: assert rst when beat 2 is shown
  task automatic run_pkt(input int len, input int mode, input bit fixed3, input logic [23:0] first3);
    logic [DW-1:0] b [BM];
    logic [PW-1:0] pr;
    logic [AW-1:0] ad;
    int idx, cyc, hold1, stall;
    @(negedge clk);
    for (int i = 0; i < BM; i++) begin
      b[i] = DW'($urandom);
      if (fixed3 && i < 3) b[i] = first3[23 - 8 * i -: 8];
      in_pack[PB - 1 - DW * i -: DW] = b[i];
    end
    pr = PW'($urandom);
    ad = AW'($urandom);
    in_prior = pr;
    in_addr = ad;
    in_len = LB'(len);
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_prior = '0;
    in_addr = '0;
    idx = 0; cyc = 0; hold1 = 0; stall = 0;
    while (idx < len && cyc < 1000) begin
      if (mode == 3 && idx == 2) break;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 2 && idx == 1 && stall < 2) ? 1'b0 : 1'b1;
      if (!out_ready) stall++;
      check("out_valid", out_valid, 1);
      check("in_ready_busy", in_ready, 0);
      check("out_data", out_data, b[idx]);
      check("out_sop", out_sop, idx == 0);
      check("out_eop", out_eop, idx == len - 1);
      check("out_prior", out_prior, pr);
      check("out_addr", out_addr, ad);
      check("no_cmd_mid", wr_ena | rd_ena, 0);
      if (idx == 1) hold1++;
      if (out_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    if (mode == 3) begin
      check("beats_before_rst", idx, 2);
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_eop", out_eop, 0);
      check("rst_cmd", {wr_ena, rd_ena, err_len}, 0);
      check("rst_prior", out_prior, 0);
      check("rst_addr", out_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) begin
        check("post_rst_quiet", {out_valid, out_eop, wr_ena, rd_ena}, 0);
        @(negedge clk);
      end
`ifdef PKT_SER_STATS_EN
      check("stat_pkts_cleared", stat_pkts, 0);
      check("stat_drops_cleared", stat_drops, 0);
`endif
      pkts_done = 0;
      out_ready = 1'b0;
      return;
    end
    check("beats_done", idx, len);
    out_ready = 1'b0;
    pkts_done++;
    check("wr_ena", wr_ena, len != RDL);
    check("rd_ena", rd_ena, len == RDL);
    check("idle_out_valid", out_valid, 0);
    check("idle_sop_eop", {out_sop, out_eop}, 0);
    check("idle_in_ready", in_ready, 1);
    check("hold_prior", out_prior, pr);
    check("hold_addr", out_addr, ad);
    if (mode == 2) check("beat1_hold_cycles", hold1, 3);
    @(negedge clk);
    check("cmd_one_cycle", {wr_ena, rd_ena}, 0);
  endtask
  initial begin
    int bad [2];
    bad[0] = 0;
    bad[1] = BM + 1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {out_sop, out_eop, wr_ena, rd_ena, err_len}, 0);
    check("reset_data", out_data, 0);
    check("reset_prior_addr", {out_prior, out_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_in_ready", in_ready, 1);
    for (int j = 0; j < 2; j++) begin
      in_len = LB'(bad[j]);
      in_pack = {PB/32{$urandom}};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("err_len_pulse", err_len, 1);
      check("err_no_valid", out_valid, 0);
      check("err_in_ready", in_ready, 1);
      @(negedge clk);
      check("err_len_clear", err_len, 0);
      check("err_still_idle", out_valid, 0);
    end
`ifdef PKT_SER_STATS_EN
    check("stat_drops_two", stat_drops, 2);
`endif
    run_pkt(3, 0, 1'b1, 24'hA1B2C3);
    run_pkt(4, 2, 1'b0, '0);
    run_pkt(1, 0, 1'b0, '0);
    run_pkt(BM, 1, 1'b0, '0);
    run_pkt(RDL, 1, 1'b0, '0);
    for (int p = 0; p < 12; p++) run_pkt($urandom_range(1, 12), 1, 1'b0, '0);
`ifdef PKT_SER_STATS_EN
    check("stat_pkts_count", stat_pkts, pkts_done);
`endif
    run_pkt(5, 3, 1'b0, '0);
    run_pkt(2, 0, 1'b0, '0);
`ifdef PKT_SER_STATS_EN
    check("stat_pkts_after_rst", stat_pkts, pkts_done);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pkt_serializer.md
PKT_SERIALIZER -- requirements
Module: pkt_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: beat width in bits.
REQ-002 SHALL have parameter BEATS_MAX, default 128: max beats per pack; PACK_BIT = DATA_WIDTH*BEATS_MAX; LEN_BIT = $clog2(BEATS_MAX+1) as localparams.
REQ-003 SHALL have parameter PRIORITY_BIT, default 3: priority field width.
REQ-004 SHALL have parameter ADDR_BIT, default 16: address field width.
REQ-005 SHALL have parameter RD_LEN, default 4: packet length classified as a read command.
REQ-006 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  in  1  pack offered.
REQ-009 SHALL have port in_ready  out  1  pack accepted when in_valid & in_ready.
REQ-010 SHALL have port in_pack  in  PACK_BIT  payload, beat 0 in MSBs.
REQ-011 SHALL have port in_len  in  LEN_BIT  beats valid in pack.
REQ-012 SHALL have port in_prior  in  PRIORITY_BIT  packet priority.
REQ-013 SHALL have port in_addr  in  ADDR_BIT  packet address.
REQ-014 SHALL have port out_valid  out  1  beat valid.
REQ-015 SHALL have port out_ready  in  1  downstream backpressure.
REQ-016 SHALL have port out_data  out  DATA_WIDTH  current beat.
REQ-017 SHALL have port out_sop  out  1  high with first beat only.
REQ-018 SHALL have port out_eop  out  1  high with last beat only.
REQ-019 SHALL have port out_prior  out  PRIORITY_BIT  latched priority, stable for whole packet.
REQ-020 SHALL have port out_addr  out  ADDR_BIT  latched address, stable for whole packet.
REQ-021 SHALL have ports wr_ena / rd_ena  out  1 each  one-cycle command pulses.
REQ-022 SHALL have port err_len  out  1  one-cycle pulse on illegal length.

Function
REQ-023 SHALL implement FSM IDLE/SEND; in_ready = 1 only in IDLE and not in reset.
REQ-024 IDLE accept with 1<=in_len<=BEATS_MAX SHALL latch pack, len, prior, addr, clear beat counter, enter SEND next cycle.
REQ-025 IDLE accept with in_len==0 or in_len>BEATS_MAX SHALL drop pack, pulse err_len next cycle, stay IDLE.
REQ-026 SEND: out_valid=1; out_data = latched[PACK_BIT-1-k*DATA_WIDTH -: DATA_WIDTH], k = beat counter.
REQ-027 Beat counter SHALL advance only on out_valid & out_ready; out_data/sop/eop SHALL hold while out_ready=0.
REQ-028 out_sop SHALL be 1 when k==0; out_eop when k==len-1; len==1 gives sop and eop on same beat.
REQ-029 Handshake on eop beat SHALL return FSM to IDLE; minimum 1 idle cycle between packets.
REQ-030 Cycle after eop handshake SHALL pulse rd_ena if len==RD_LEN, else wr_ena; never both.
REQ-031 out_valid, sop, eop SHALL be 0 in IDLE; out_prior/out_addr hold last packet values.

Reset
REQ-032 rst SHALL force IDLE, counter 0, all outputs 0 (in_ready 0 during rst, 1 the cycle after).
REQ-033 rst mid-packet SHALL abandon packet with no eop, wr_ena, rd_ena.

Configuration
REQ-034 With PKT_SER_STATS_EN defined: outputs stat_pkts [31:0] (increments per completed packet) and stat_drops [15:0] (increments per err_len, saturating), both cleared by rst.
REQ-035 Without PKT_SER_STATS_EN: stats ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-036 Package pkt_ser_pkg SHALL hold FSM state enum and default parameter constants.
REQ-037 Beat selection mux SHALL be sub-module pkt_ser_beat_sel (combinational, parametrised).

Verification
REQ-038 len=3, pack MSBs 0xA1,0xB2,0xC3, out_ready=1 -> beats A1(sop),B2,C3(eop) on consecutive cycles, wr_ena pulse.
REQ-039 len=4, out_ready low 2 cycles at beat 1 -> beat 1 held 3 cycles, 4 beats total, rd_ena pulse.
REQ-040 len=1 -> single beat with sop=eop=1, wr_ena pulse.
REQ-041 len=0 then len=129 -> two err_len pulses, no out_valid, stat_drops=2 when PKT_SER_STATS_EN.
REQ-042 rst after beat 2 of len=5 -> no eop, no command pulse, in_ready=1 the cycle after rst drops.
